path_extract: RTL and testbench

PATH_EXTRACT -- requirements
Module: path_extract

---
 rtl/path_extract.sv | 206 ++++++++++++++++++++
 tb/tb_path_extract.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/path_extract.sv
// Backtracks a roadmap path from goal to origin using edges from a backward search,
// buffers the point ids, then streams them out in origin-to-goal order.
//   state   | meaning
//   IDLE    | waiting for start
//   COLLECT | accepting edges, extending the path from cur
//   EMIT    | streaming buffered points, last stored first
//   ERR     | sticky error until the next start
module path_extract #(
  parameter int DEPTH  = 16,
  parameter int NPOINT = 66,
  parameter int NEDGE  = 1034
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         start,
  input  logic [7:0]                   startPoint,
  input  logic [7:0]                   endPoint,
  input  logic                         edge_valid,
  input  logic [10:0]                  edge_index,
  input  logic [NPOINT-1:0]            edge_route,
  output logic                         edge_ready,
  input  logic                         done_in,
  output logic                         pt_valid,
  output logic [7:0]                   pt_data,
  output logic                         pt_last,
  input  logic                         pt_ready,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   path_len,
  output logic                         err,
  output logic [1:0]                   err_code
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_EMIT, S_ERR} state_t;

  state_t          r_state;
  logic [7:0]      r_buf [DEPTH];
  logic [7:0]      r_cur;
  logic [7:0]      r_start_pt;
  logic [AW-1:0]   r_rd_idx;
  logic [LW-1:0]   r_path_len;
  logic            r_edge_ready;
  logic            r_pt_valid;
  logic [7:0]      r_pt_data;
  logic            r_pt_last;
  logic            r_err;
  logic [1:0]      r_err_code;

  int              w_pop;
  logic            w_hit;
  logic [7:0]      w_next;
  logic            w_edge_acc;
  logic            w_edge_ok;
  logic            w_full;
  logic            w_complete;
  logic            w_pts_ok;
  logic            w_start_ok;
  logic            w_fail;
  logic [1:0]      w_fail_code;
  logic            w_advance;
  logic            w_buf_we;
  logic [AW-1:0]   w_buf_waddr;
  logic [7:0]      w_buf_wdata;

  // The far endpoint is whichever set bit is not cur; validity is checked separately.
  always_comb begin
    w_pop  = 0;
    w_hit  = 1'b0;
    w_next = '0;
    for (int i = 0; i < NPOINT; i++) begin
      w_pop = w_pop + int'(edge_route[i]);
      if (i == int'(r_cur)) w_hit = edge_route[i];
      else if (edge_route[i]) w_next = 8'(i);
    end
  end

  assign w_edge_acc = (r_state == S_COLLECT) && edge_valid && r_edge_ready;
  assign w_edge_ok  = (w_pop == 2) && w_hit && (int'(edge_index) < NEDGE);
  assign w_full     = (r_path_len == LW'(DEPTH));
  assign w_complete = (w_next == r_start_pt);
  assign w_pts_ok   = (int'(startPoint) < NPOINT) && (int'(endPoint) < NPOINT);
  assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_ERR)) && w_pts_ok;

  // An edge arriving with done_in is processed first; only a completing edge escapes the error.
  always_comb begin
    w_fail      = 1'b0;
    w_fail_code = 2'd0;
    w_advance   = 1'b0;
    if (w_edge_acc) begin
      if (!w_edge_ok) begin
        w_fail      = 1'b1;
        w_fail_code = 2'd2;
      end else if (w_full) begin
        w_fail      = 1'b1;
        w_fail_code = 2'd3;
      end else begin
        w_advance = 1'b1;
        if (!w_complete && done_in) w_fail = 1'b1;
      end
    end else if (done_in) begin
      w_fail = 1'b1;
    end
  end

  always_comb begin
    w_buf_we    = 1'b0;
    w_buf_waddr = '0;
    w_buf_wdata = endPoint;
    if (w_start_ok) begin
      w_buf_we = 1'b1;
    end else if (w_advance && !w_fail) begin
      w_buf_we    = 1'b1;
      w_buf_waddr = r_path_len[AW-1:0];
      w_buf_wdata = w_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_buf_we) r_buf[w_buf_waddr] <= w_buf_wdata;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= S_IDLE;
      r_cur        <= '0;
      r_start_pt   <= '0;
      r_rd_idx     <= '0;
      r_path_len   <= '0;
      r_edge_ready <= 1'b0;
      r_pt_valid   <= 1'b0;
      r_pt_data    <= '0;
      r_pt_last    <= 1'b0;
      r_err        <= 1'b0;
      r_err_code   <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE, S_ERR: begin
          if (start) begin
            if (!w_pts_ok) begin
              r_state      <= S_ERR;
              r_err        <= 1'b1;
              r_err_code   <= 2'd1;
              r_edge_ready <= 1'b0;
            end else begin
              r_cur      <= endPoint;
              r_start_pt <= startPoint;
              r_path_len <= LW'(1);
              r_rd_idx   <= '0;
              r_err      <= 1'b0;
              r_err_code <= 2'd0;
              if (startPoint == endPoint) begin
                r_state <= S_EMIT;
              end else begin
                r_state      <= S_COLLECT;
                r_edge_ready <= 1'b1;
              end
            end
          end
        end
        S_COLLECT: begin
          if (w_fail) begin
            r_state      <= S_ERR;
            r_err        <= 1'b1;
            r_err_code   <= w_fail_code;
            r_edge_ready <= 1'b0;
          end else if (w_advance) begin
            r_path_len <= r_path_len + LW'(1);
            r_cur      <= w_next;
            if (w_complete) begin
              r_state      <= S_EMIT;
              r_edge_ready <= 1'b0;
              r_rd_idx     <= r_path_len[AW-1:0];
            end
          end
        end
        S_EMIT: begin
          if (!r_pt_valid) begin
            r_pt_valid <= 1'b1;
            r_pt_data  <= r_buf[r_rd_idx];
            r_pt_last  <= (r_rd_idx == '0);
          end else if (pt_ready) begin
            if (r_pt_last) begin
              r_pt_valid <= 1'b0;
              r_state    <= S_IDLE;
            end else begin
              r_rd_idx  <= r_rd_idx - AW'(1);
              r_pt_data <= r_buf[r_rd_idx - AW'(1)];
              r_pt_last <= (r_rd_idx == AW'(1));
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy       = (r_state == S_COLLECT) || (r_state == S_EMIT);
  assign edge_ready = r_edge_ready;
  assign pt_valid   = r_pt_valid;
  assign pt_data    = r_pt_data;
  assign pt_last    = r_pt_last;
  assign path_len   = r_path_len;
  assign err        = r_err;
  assign err_code   = r_err_code;
endmodule

// File: tb/tb_path_extract.sv
// Bench for path_extract: expected points are queued when a path is set up and
// compared as the DUT hands them out.
module tb_path_extract;
  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  startPoint = '0;
  logic [7:0]  endPoint = '0;
  logic        edge_valid = 1'b0;
  logic [10:0] edge_index = '0;
  logic [65:0] edge_route = '0;
  logic        done_in = 1'b0;
  logic        pt_ready = 1'b1;
  logic        edge_ready, pt_valid, pt_last, busy, err;
  logic [7:0]  pt_data;
  logic [4:0]  path_len;
  logic [1:0]  err_code;

  int          n_checks = 0;
  int          n_err = 0;
  int          pv_cnt = 0;
  int          pv_snap;
  logic [8:0]  sb_q[$];
  logic [8:0]  mon_e;

  path_extract dut (
    .CLK(CLK), .RST(RST), .start(start), .startPoint(startPoint), .endPoint(endPoint),
    .edge_valid(edge_valid), .edge_index(edge_index), .edge_route(edge_route),
    .edge_ready(edge_ready), .done_in(done_in), .pt_valid(pt_valid), .pt_data(pt_data),
    .pt_last(pt_last), .pt_ready(pt_ready), .busy(busy), .path_len(path_len),
    .err(err), .err_code(err_code)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (!RST) begin
      if (pt_valid) pv_cnt++;
      if (pt_valid && pt_ready) begin
        check("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
          mon_e = sb_q.pop_front();
          check("pt_data", 32'(pt_data), 32'(mon_e[7:0]));
          check("pt_last", 32'(pt_last), 32'(mon_e[8]));
        end
      end
    end
  end

  task automatic do_start(input int s, input int e);
    @(negedge CLK);
    start = 1'b1;
    startPoint = 8'(s);
    endPoint = 8'(e);
    @(posedge CLK);
    #1 start = 1'b0;
  endtask

  task automatic send_edge(input int idx, input int a, input int b, input logic with_done);
    bit ok;
    ok = 0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge CLK);
      if (edge_ready) ok = 1;
    end
    check("edge_ready_wait", 32'(edge_ready), 32'd1);
    edge_valid = 1'b1;
    edge_index = 11'(idx);
    edge_route = (66'd1 << a) | (66'd1 << b);
    done_in = with_done;
    @(posedge CLK);
    #1;
    edge_valid = 1'b0;
    done_in = 1'b0;
  endtask

  task automatic pulse_done();
    @(negedge CLK);
    done_in = 1'b1;
    @(posedge CLK);
    #1 done_in = 1'b0;
  endtask

  task automatic wait_pt_valid();
    for (int k = 0; k < 50; k++) begin
      @(negedge CLK);
      if (pt_valid) break;
    end
    check("pt_valid_wait", 32'(pt_valid), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 200; k++) begin
      @(negedge CLK);
      if (!busy && sb_q.size() == 0) break;
    end
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_drained"}, 32'(sb_q.size()), 32'd0);
  endtask

  task automatic push_path_0_12_5();
    sb_q.push_back({1'b0, 8'd0});
    sb_q.push_back({1'b0, 8'd12});
    sb_q.push_back({1'b1, 8'd5});
  endtask

  initial begin
    #2 RST = 1'b1;
    #10;
    check("rst_edge_ready", 32'(edge_ready), 32'd0);
    check("rst_pt_valid", 32'(pt_valid), 32'd0);
    check("rst_pt_data", 32'(pt_data), 32'd0);
    check("rst_pt_last", 32'(pt_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_path_len", 32'(path_len), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    // Out-of-range origin
    do_start(70, 5);
    check("badpt_err", 32'(err), 32'd1);
    check("badpt_code", 32'(err_code), 32'd1);
    check("badpt_busy", 32'(busy), 32'd0);

    // Basic three-point path
    push_path_0_12_5();
    do_start(0, 5);
    check("p1_busy", 32'(busy), 32'd1);
    check("p1_err_clr", 32'(err), 32'd0);
    check("p1_len1", 32'(path_len), 32'd1);
    send_edge(40, 5, 12, 1'b0);
    check("p1_len2", 32'(path_len), 32'd2);
    send_edge(7, 12, 0, 1'b0);
    check("p1_ready_low", 32'(edge_ready), 32'd0);
    wait_idle("p1");
    check("p1_len3", 32'(path_len), 32'd3);

    // Backpressure on the first point
    pt_ready = 1'b0;
    push_path_0_12_5();
    do_start(0, 5);
    send_edge(40, 5, 12, 1'b0);
    send_edge(7, 12, 0, 1'b0);
    wait_pt_valid();
    for (int h = 0; h < 3; h++) begin
      if (h > 0) @(negedge CLK);
      check("hold_valid", 32'(pt_valid), 32'd1);
      check("hold_data", 32'(pt_data), 32'd0);
      check("hold_last", 32'(pt_last), 32'd0);
    end
    @(posedge CLK);
    #1 pt_ready = 1'b1;
    wait_idle("p2");

    // Edge not touching cur
    do_start(0, 5);
    pv_snap = pv_cnt;
    send_edge(99, 7, 9, 1'b0);
    check("badedge_err", 32'(err), 32'd1);
    check("badedge_code", 32'(err_code), 32'd2);
    check("badedge_ready", 32'(edge_ready), 32'd0);
    repeat (5) @(negedge CLK);
    check("badedge_no_pt", 32'(pv_cnt), 32'(pv_snap));

    // Buffer overflow
    do_start(0, 1);
    for (int k = 1; k <= 15; k++) send_edge(k, k, k + 1, 1'b0);
    check("ovf_len16", 32'(path_len), 32'd16);
    check("ovf_no_err_yet", 32'(err), 32'd0);
    send_edge(16, 16, 17, 1'b0);
    check("ovf_err", 32'(err), 32'd1);
    check("ovf_code", 32'(err_code), 32'd3);

    // Search finishes early, then single-point path
    do_start(0, 5);
    send_edge(40, 5, 12, 1'b0);
    pulse_done();
    check("inc_err", 32'(err), 32'd1);
    check("inc_code", 32'(err_code), 32'd0);
    check("inc_ready", 32'(edge_ready), 32'd0);
    sb_q.push_back({1'b1, 8'd3});
    do_start(3, 3);
    check("single_busy", 32'(busy), 32'd1);
    wait_idle("single");
    check("single_len", 32'(path_len), 32'd1);
    check("single_err", 32'(err), 32'd0);

    // Completing edge arrives together with done_in
    push_path_0_12_5();
    do_start(0, 5);
    send_edge(40, 5, 12, 1'b0);
    send_edge(7, 12, 0, 1'b1);
    check("same_cyc_err", 32'(err), 32'd0);
    wait_idle("same_cyc");
    check("same_cyc_len", 32'(path_len), 32'd3);

    // Reset during emission
    sb_q.push_back({1'b0, 8'd0});
    do_start(0, 5);
    send_edge(40, 5, 12, 1'b0);
    send_edge(7, 12, 0, 1'b0);
    wait_pt_valid();
    @(posedge CLK);
    #1 RST = 1'b1;
    #1;
    check("midrst_pt_valid", 32'(pt_valid), 32'd0);
    check("midrst_path_len", 32'(path_len), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    pv_snap = pv_cnt;
    @(negedge CLK);
    RST = 1'b0;
    repeat (10) @(negedge CLK);
    check("midrst_no_pt", 32'(pv_cnt), 32'(pv_snap));
    check("midrst_idle", 32'(busy), 32'd0);
    check("midrst_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "simulation watchdog expired");
  end
endmodule
